// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the integer register file write port,
// with pending-write hazard reporting. Optional forwarding: RF_WB_FORWARD_EN.
module rf_wb_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_wa,
    output logic [XLEN-1:0]      rf_wd,
    input  logic [AW-1:0]        ra1,
    input  logic [AW-1:0]        ra2,
    output logic                 pend_hit1,
    output logic                 pend_hit2
`ifdef RF_WB_FORWARD_EN
    ,
    output logic                 fwd1_valid,
    output logic                 fwd2_valid,
    output logic [XLEN-1:0]      fwd1_data,
    output logic [XLEN-1:0]      fwd2_data
`endif
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]           full_q, full_d;
    logic [NREQ-1:0][AW-1:0]   addr_q, addr_d;
    logic [NREQ-1:0][XLEN-1:0] data_q, data_d;
    logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
    logic                      rf_we_q, rf_we_d;
    logic [AW-1:0]             rf_wa_q, rf_wa_d;
    logic [XLEN-1:0]           rf_wd_q, rf_wd_d;

    logic [NREQ-1:0]           grant;
    logic [NREQ-1:0]           accept;
    logic                      gnt_found;
    logic [PW-1:0]             gnt_idx;

    // First full slot at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int          idx;
        logic [PW-1:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        grant     = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(NREQ)) begin
                idx = idx - int'(NREQ);
            end
            cand = PW'(idx);
            if (!gnt_found && full_q[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (gnt_found) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    // A slot being granted this cycle can take a new entry on the same edge.
    assign req_ready = rst ? '0 : (~full_q | grant);
    assign accept    = req_valid & req_ready;

    always_comb begin
        full_d   = full_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        rf_we_d  = 1'b0;
        rf_wa_d  = rf_wa_q;
        rf_wd_d  = rf_wd_q;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) begin
                full_d[i] = 1'b0;
            end
            if (accept[i]) begin
                full_d[i] = 1'b1;
                addr_d[i] = req_addr[i*AW +: AW];
                data_d[i] = req_data[i*XLEN +: XLEN];
            end
        end
        if (gnt_found) begin
            rr_ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
            // Writes to x0 free the slot but never reach the register file.
            if (addr_q[gnt_idx] != '0) begin
                rf_we_d = 1'b1;
                rf_wa_d = addr_q[gnt_idx];
                rf_wd_d = data_q[gnt_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rr_ptr_q <= '0;
            rf_we_q  <= 1'b0;
            rf_wa_q  <= '0;
            rf_wd_q  <= '0;
        end else begin
            full_q   <= full_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rr_ptr_q <= rr_ptr_d;
            rf_we_q  <= rf_we_d;
            rf_wa_q  <= rf_wa_d;
            rf_wd_q  <= rf_wd_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_wa = rf_wa_q;
    assign rf_wd = rf_wd_q;

    logic slot_hit1, slot_hit2, out_hit1, out_hit2;
    logic ra1_nz, ra2_nz;

    always_comb begin
        slot_hit1 = 1'b0;
        slot_hit2 = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (full_q[i] && (addr_q[i] == ra1)) slot_hit1 = 1'b1;
            if (full_q[i] && (addr_q[i] == ra2)) slot_hit2 = 1'b1;
        end
    end

    assign ra1_nz   = (ra1 != '0);
    assign ra2_nz   = (ra2 != '0);
    assign out_hit1 = rf_we_q && (rf_wa_q == ra1);
    assign out_hit2 = rf_we_q && (rf_wa_q == ra2);

`ifdef RF_WB_FORWARD_EN
    // The in-flight write is forwarded instead of stalling issue.
    assign pend_hit1  = ra1_nz & slot_hit1;
    assign pend_hit2  = ra2_nz & slot_hit2;
    assign fwd1_valid = ra1_nz & out_hit1;
    assign fwd2_valid = ra2_nz & out_hit2;
    assign fwd1_data  = rf_wd_q;
    assign fwd2_data  = rf_wd_q;
`else
    assign pend_hit1 = ra1_nz & (slot_hit1 | out_hit1);
    assign pend_hit2 = ra2_nz & (slot_hit2 | out_hit2);
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (NREQ=3, XLEN=32, AW=5).
module tb_rf_wb_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic                 rf_we;
    logic [AW-1:0]        rf_wa;
    logic [XLEN-1:0]      rf_wd;
    logic [AW-1:0]        ra1;
    logic [AW-1:0]        ra2;
    logic                 pend_hit1;
    logic                 pend_hit2;
`ifdef RF_WB_FORWARD_EN
    logic                 fwd1_valid, fwd2_valid;
    logic [XLEN-1:0]      fwd1_data, fwd2_data;
`endif

    int tests = 0;
    int fails = 0;

    rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .ra1       (ra1),
        .ra2       (ra2),
        .pend_hit1 (pend_hit1),
        .pend_hit2 (pend_hit2)
`ifdef RF_WB_FORWARD_EN
        ,
        .fwd1_valid(fwd1_valid),
        .fwd2_valid(fwd2_valid),
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        req_addr[i*AW +: AW]     = a;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0) begin
            fails++;
            $display("FAIL reset_out: we=%b wa=%0d wd=%h exp 0/0/0", rf_we, rf_wa, rf_wd);
        end
        tests++;
        if (req_ready !== 3'b000) begin
            fails++;
            $display("FAIL reset_ready: got %b exp 000", req_ready);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (req_ready !== 3'b111) begin
            fails++;
            $display("FAIL ready_after_reset: got %b exp 111", req_ready);
        end
    endtask

    // All three requesters at once; rr_ptr must be 0 on entry.
    task automatic test_contention(input string tag);
        logic [AW-1:0]   exp_wa [3];
        logic [XLEN-1:0] exp_wd [3];
        exp_wa = '{5'd1, 5'd2, 5'd3};
        exp_wd = '{32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003};
        for (int i = 0; i < 3; i++) set_req(i, exp_wa[i], exp_wd[i]);
        req_valid = 3'b111;
        tick();
        req_valid = 3'b000;
        tests++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("FAIL %s_e0_we: got %b exp 0", tag, rf_we);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (rf_we !== 1'b1 || rf_wa !== exp_wa[i] || rf_wd !== exp_wd[i]) begin
                fails++;
                $display("FAIL %s_w%0d: we=%b wa=%0d wd=%h exp 1/%0d/%h",
                         tag, i, rf_we, rf_wa, rf_wd, exp_wa[i], exp_wd[i]);
            end
        end
        tick();
        tests++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle_we: got %b exp 0", tag, rf_we);
        end
        tests++;
        if (dut.rr_ptr_q !== 2'd0) begin
            fails++;
            $display("FAIL %s_rr_ptr: got %0d exp 0", tag, dut.rr_ptr_q);
        end
    endtask

    task automatic test_single_write();
        set_req(0, 5'd5, 32'hDEAD_BEEF);
        req_valid = 3'b001;
        tests++;
        if (req_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL single_ready: got %b exp 1", req_ready[0]);
        end
        tick();
        req_valid = 3'b000;
        tests++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("FAIL single_e0_we: got %b exp 0", rf_we);
        end
        tick();
        tests++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL single_e1: we=%b wa=%0d wd=%h exp 1/5/deadbeef", rf_we, rf_wa, rf_wd);
        end
        tick();
        tests++;
        if (rf_we !== 1'b0 || rf_wa !== 5'd5 || rf_wd !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL single_e2_hold: we=%b wa=%0d wd=%h exp 0/5/deadbeef", rf_we, rf_wa, rf_wd);
        end
    endtask

    task automatic test_x0_drop();
        set_req(1, 5'd0, 32'hFFFF_FFFF);
        req_valid = 3'b010;
        tick();
        req_valid = 3'b000;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (rf_we !== 1'b0 || rf_wa !== 5'd5 || rf_wd !== 32'hDEAD_BEEF) begin
                fails++;
                $display("FAIL x0_c%0d: we=%b wa=%0d wd=%h exp 0/5/deadbeef", c, rf_we, rf_wa, rf_wd);
            end
            tick();
        end
        tests++;
        if (req_ready[1] !== 1'b1) begin
            fails++;
            $display("FAIL x0_ready: got %b exp 1", req_ready[1]);
        end
    endtask

    task automatic test_hazard();
        logic exp_hit_out;
`ifdef RF_WB_FORWARD_EN
        exp_hit_out = 1'b0;
`else
        exp_hit_out = 1'b1;
`endif
        ra1 = 5'd7;
        ra2 = 5'd0;
        set_req(2, 5'd7, 32'h0000_0777);
        req_valid = 3'b100;
        #1;
        tests++;
        if (pend_hit1 !== 1'b0 || pend_hit2 !== 1'b0) begin
            fails++;
            $display("FAIL haz_pre: hit1=%b hit2=%b exp 0/0", pend_hit1, pend_hit2);
        end
        tick();
        req_valid = 3'b000;
        tests++;
        if (pend_hit1 !== 1'b1 || pend_hit2 !== 1'b0) begin
            fails++;
            $display("FAIL haz_slot: hit1=%b hit2=%b exp 1/0", pend_hit1, pend_hit2);
        end
        tick();
        tests++;
        if (rf_we !== 1'b1 || pend_hit1 !== exp_hit_out || pend_hit2 !== 1'b0) begin
            fails++;
            $display("FAIL haz_out: we=%b hit1=%b hit2=%b exp 1/%b/0", rf_we, pend_hit1, pend_hit2, exp_hit_out);
        end
`ifdef RF_WB_FORWARD_EN
        tests++;
        if (fwd1_valid !== 1'b1 || fwd1_data !== 32'h0000_0777 || fwd2_valid !== 1'b0) begin
            fails++;
            $display("FAIL haz_fwd: v1=%b d1=%h v2=%b exp 1/777/0", fwd1_valid, fwd1_data, fwd2_valid);
        end
`endif
        tick();
        tests++;
        if (pend_hit1 !== 1'b0 || pend_hit2 !== 1'b0) begin
            fails++;
            $display("FAIL haz_done: hit1=%b hit2=%b exp 0/0", pend_hit1, pend_hit2);
        end
        ra1 = 5'd0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            set_req(0, 5'(8 + i), 32'(32'hB000_0000 + i));
            req_valid = 3'b001;
            #1;
            tests++;
            if (req_ready[0] !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready%0d: got %b exp 1", i, req_ready[0]);
            end
            tick();
            if (i >= 1) begin
                tests++;
                if (rf_we !== 1'b1 || rf_wa !== 5'(8 + i - 1) || rf_wd !== 32'(32'hB000_0000 + i - 1)) begin
                    fails++;
                    $display("FAIL b2b_w%0d: we=%b wa=%0d wd=%h exp 1/%0d", i - 1, rf_we, rf_wa, rf_wd, 8 + i - 1);
                end
            end
        end
        req_valid = 3'b000;
        tick();
        tests++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd11 || rf_wd !== 32'hB000_0003) begin
            fails++;
            $display("FAIL b2b_w3: we=%b wa=%0d wd=%h exp 1/11/b0000003", rf_we, rf_wa, rf_wd);
        end
        tick();
        tests++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: got %b exp 0", rf_we);
        end
    endtask

    task automatic test_reset_mid_op();
        set_req(0, 5'd12, 32'hC0);
        set_req(1, 5'd13, 32'hC1);
        set_req(2, 5'd14, 32'hC2);
        req_valid = 3'b111;
        tick();
        req_valid = 3'b000;
        tick();
        tests++;
        // rr_ptr is 1 after the back-to-back run, so slot 1 wins first.
        if (rf_we !== 1'b1 || rf_wa !== 5'd13) begin
            fails++;
            $display("FAIL mid_pre: we=%b wa=%0d exp 1/13", rf_we, rf_wa);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (rf_we !== 1'b0 || rf_wa !== 5'd0 || req_ready !== 3'b000) begin
            fails++;
            $display("FAIL mid_rst: we=%b wa=%0d ready=%b exp 0/0/000", rf_we, rf_wa, req_ready);
        end
        tick();
        rst = 1'b0;
        ra1 = 5'd14;
        ra2 = 5'd12;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests++;
            if (rf_we !== 1'b0 || pend_hit1 !== 1'b0 || pend_hit2 !== 1'b0) begin
                fails++;
                $display("FAIL mid_stale%0d: we=%b hit1=%b hit2=%b exp 0/0/0", c, rf_we, pend_hit1, pend_hit2);
            end
            tick();
        end
        ra1 = 5'd0;
        ra2 = 5'd0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        ra1       = '0;
        ra2       = '0;
        test_reset();
        test_contention("cont1");
        test_contention("cont2");
        test_single_write();
        test_x0_drop();
        test_hazard();
        test_back_to_back();
        test_reset_mid_op();
        test_contention("cont_post_rst");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
